// File: rtl/pattern_history_table.sv
`default_nettype none
// ============================================================================
// Module   : pattern_history_table
// Purpose  : gshare-style table of 2-bit saturating counters. IF looks up a
//            prediction combinationally from PC XOR global history; EX trains
//            the indexed counter one cycle later. Also keeps saturating
//            resolved-branch and misprediction statistics counters.
// Revision : 1.0  initial release
// ============================================================================
module pattern_history_table #(
  parameter int INDEX_BITS = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IF-side lookup
  input  logic                  IF_lookup,
  input  logic [31:0]           IF_pc,
  input  logic [INDEX_BITS-1:0] bhr_in,
  output logic                  IF_predict_taken,
  output logic [INDEX_BITS-1:0] IF_pht_index,
  // EX-side training
  input  logic                  EX_update,
  input  logic [INDEX_BITS-1:0] EX_pht_index,
  input  logic                  EX_branch_flag,
  input  logic                  EX_predicted,
  output logic                  EX_mispredict,
  // statistics
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int              c_ENTRIES   = 1 << INDEX_BITS;
  localparam logic [1:0]      c_WEAK_NT   = 2'b01;
  localparam logic [1:0]      c_STRONG_T  = 2'b11;
  localparam logic [1:0]      c_STRONG_NT = 2'b00;
  localparam logic [STAT_WIDTH-1:0] c_STAT_MAX = '1;

  logic [1:0]            r_table [c_ENTRIES];
  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispredict_count;
  logic [INDEX_BITS-1:0] w_index;
  logic                  w_mispredict;
  logic                  w_unused_pc;

  // Word-aligned PC bits hashed with global history; byte offset is ignored.
  assign w_index          = IF_pc[INDEX_BITS+1:2] ^ bhr_in;
  assign IF_pht_index     = w_index;
  // Lookup reads the stored state only, so a same-cycle update is not visible.
  assign IF_predict_taken = IF_lookup & r_table[w_index][1];

  assign w_mispredict  = EX_update & (EX_branch_flag ^ EX_predicted);
  assign EX_mispredict = w_mispredict;

  // PC bits outside the index window play no part in the hash.
  assign w_unused_pc = ^{IF_pc[31:INDEX_BITS+2], IF_pc[1:0]};

  // Counter table: reset to weak not-taken, otherwise saturating train of one entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= c_WEAK_NT;
      end
    end else if (EX_update) begin
      if (EX_branch_flag) begin
        if (r_table[EX_pht_index] != c_STRONG_T) begin
          r_table[EX_pht_index] <= r_table[EX_pht_index] + 2'd1;
        end
      end else begin
        if (r_table[EX_pht_index] != c_STRONG_NT) begin
          r_table[EX_pht_index] <= r_table[EX_pht_index] - 2'd1;
        end
      end
    end
  end

  // Statistics: saturating counts of resolved branches and mispredictions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (EX_update && (r_branch_count != c_STAT_MAX)) begin
        r_branch_count <= r_branch_count + 1'b1;
      end
      if (w_mispredict && (r_mispredict_count != c_STAT_MAX)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: doc/pattern_history_table.md
# pattern_history_table

Consumer of the 4-bit branch history: a gshare-style table of 2-bit saturating counters that turns fetch PC plus global history into a taken/not-taken prediction. It sits between IF and EX. IF reads it combinationally. EX writes it back through a registered update port when a branch resolves. It also keeps saturating branch and misprediction statistics counters for performance measurement.

## Interface
- INDEX_BITS, 4, table index width and history width; table holds 2^INDEX_BITS counters
- STAT_WIDTH, 16, width of each statistics counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- IF_lookup  input  1  IF stage holds a branch needing a prediction
- IF_pc  input  32  fetch PC
- bhr_in  input  INDEX_BITS  current global history; bit 0 newest outcome
- IF_predict_taken  output  1  prediction for IF_pc
- IF_pht_index  output  INDEX_BITS  index used for this lookup; carried down the pipe to EX
- EX_update  input  1  a branch resolved in EX this cycle
- EX_pht_index  input  INDEX_BITS  index carried from IF for the resolving branch
- EX_branch_flag  input  1  actual outcome, 1 = taken
- EX_predicted  input  1  prediction made for that branch in IF
- EX_mispredict  output  1  resolving branch was mispredicted
- branch_count  output  STAT_WIDTH  resolved branches since reset
- mispredict_count  output  STAT_WIDTH  mispredictions since reset

## Operation
- Index: IF_pht_index = IF_pc[INDEX_BITS+1:2] XOR bhr_in. IF_pc[1:0] is ignored.
- Counter encoding:
  - 00 strong not-taken
  - 01 weak not-taken
  - 10 weak taken
  - 11 strong taken
- IF_predict_taken = IF_lookup AND counter[IF_pht_index][1]. It is 0 whenever IF_lookup = 0.
- Update, when EX_update = 1 and rst_n = 1:
  - EX_branch_flag = 1: counter[EX_pht_index] increments, saturating at 11.
  - EX_branch_flag = 0: counter[EX_pht_index] decrements, saturating at 00.
  - Only that one entry changes.
- EX_mispredict = EX_update AND (EX_branch_flag XOR EX_predicted). It is combinational and is 0 when EX_update = 0.
- branch_count increments by 1 on each cycle with EX_update = 1. It saturates at all-ones and never wraps.
- mispredict_count increments by 1 on each cycle with EX_mispredict = 1. It saturates at all-ones and never wraps.
- The table does not hold history. bhr_in is read only. Shifting the history is the history register's job.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - Every table entry becomes 01 (weak not-taken).
  - branch_count and mispredict_count become 0.
  - Any EX_update in that cycle is discarded: no counter change, no statistics change.
- After reset, IF_predict_taken = 0 for every index until that index is trained.
- Lookup latency: 0 cycles. IF_predict_taken and IF_pht_index are combinational from IF_pc, bhr_in, IF_lookup and current table state.
- Update latency: 1 cycle. The new counter value is visible to lookups from the cycle after EX_update.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value. There is no write-through bypass.
- Simultaneous lookup and update to different indices: the two are independent.
- Statistics outputs are registered. They reflect updates from previous cycles only.
- At saturation, further increments hold the value. The counter stays at all-ones until reset.
- Reset asserted mid-stream re-initialises everything at that edge regardless of in-flight EX updates. Pipeline flushing is the pipeline's responsibility.
- There is no handshake or backpressure. An update is accepted every cycle EX_update = 1, including back-to-back updates to the same index, each of which steps the counter once.

## Test plan
- Reset then lookup:
  - Stimulus: rst_n = 0 for 1 cycle, then IF_lookup = 1 with IF_pc = 0x00000040 and bhr_in = 4'b0000.
  - Required: IF_pht_index = 4'h0, IF_predict_taken = 0, both statistics counters = 0.
- Hashing:
  - Stimulus: IF_pc = 0x0000003C, bhr_in = 4'b0101.
  - Required: IF_pht_index = 4'hF XOR 4'h5 = 4'hA.
- Saturation up:
  - Stimulus: four back-to-back updates to index 3, taken, each with EX_predicted = 0.
  - Required: prediction at index 3 becomes 1 after the first update and the counter holds at 11.
  - Required: mispredict_count = 4, branch_count = 4.
- Saturation down:
  - Stimulus: from 11, three not-taken updates.
  - Required: prediction flips to 0 after the second update and the counter ends at 00.
  - Stimulus: a fourth not-taken update.
  - Required: counter stays at 00.
- Same-cycle read/update collision:
  - Stimulus: index 5 at 01; lookup and a taken update to index 5 in the same cycle.
  - Required: IF_predict_taken = 0 that cycle and 1 in the next cycle.
- Reset mid-operation and statistics saturation:
  - Stimulus: preload branch_count to 0xFFFE via updates; apply 3 more updates.
  - Required: branch_count holds at 0xFFFF.
  - Stimulus: rst_n = 0 coincident with EX_update = 1.
  - Required: all counters return to 0 and all entries to 01, with no update applied.
